// File: rtl/cbrt_pkg.sv
// Shared types and sizing for the cube-root engine and its display consumer.
package cbrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } cbrt_state_t;

    localparam int CBRT_WIDTH = 20;

    // Root width and iteration count for a given operand width.
    function automatic int cbrt_rw(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/cbrt_step.sv
// One digit-recurrence step of the cube root: (x, y, s) -> (x', y').
module cbrt_step #(
    parameter int WIDTH = 20,
    parameter int RW    = 7,
    parameter int SW    = 5
) (
    input  logic [WIDTH-1:0] x,
    input  logic [RW-1:0]    y,
    input  logic [SW-1:0]    s,
    output logic [WIDTH-1:0] x_next,
    output logic [RW-1:0]    y_next
);

    localparam int IW = WIDTH + 2;

    logic [IW-1:0] x_ext_s;
    logic [IW-1:0] y2_s;
    logic [IW-1:0] y2p1_s;
    logic [IW-1:0] b_s;
    logic [IW-1:0] xs_s;
    logic [IW-1:0] sub_s;
    logic          unused_s;

    assign x_ext_s = {2'b00, x};
    assign y2_s    = IW'(y) << 1;
    assign y2p1_s  = y2_s + IW'(1);
    assign b_s     = IW'(3) * y2_s * y2p1_s + IW'(1);
    // Compare against shifted x so b is never shifted past the top bit.
    assign xs_s    = x_ext_s >> s;
    assign sub_s   = x_ext_s - (b_s << s);
    assign unused_s = ^{sub_s[IW-1:WIDTH], y2_s[IW-1:RW], y2p1_s[IW-1:RW]};

    // Accept or reject the trial bit.
    always_comb begin
        x_next = x;
        y_next = y2_s[RW-1:0];
        if (xs_s >= b_s) begin
            x_next = sub_s[WIDTH-1:0];
            y_next = y2p1_s[RW-1:0];
        end else begin
            x_next = x;
            y_next = y2_s[RW-1:0];
        end
    end

endmodule

// File: rtl/cbrt_engine.sv
// Sequential floor(cbrt(operand)) engine, one root bit per clock.
// Define CBRT_REM_EN to export operand - root^3 on the remainder port.
module cbrt_engine
    import cbrt_pkg::*;
#(
    parameter int WIDTH = CBRT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          operand,
    output logic                      busy,
    output logic                      done,
    output logic [cbrt_rw(WIDTH)-1:0] root
`ifdef CBRT_REM_EN
    ,
    output logic [WIDTH-1:0]          remainder
`endif
);

    localparam int RW = cbrt_rw(WIDTH);
    localparam int SW = $clog2(3 * RW + 1);
    localparam logic [SW-1:0] S_INIT = SW'(3 * (RW - 1));
    localparam logic [SW-1:0] S_STEP = SW'(3);

    cbrt_state_t      state_r;
    cbrt_state_t      state_nxt_s;
    logic [WIDTH-1:0] x_r;
    logic [RW-1:0]    y_r;
    logic [SW-1:0]    s_r;
    logic [WIDTH-1:0] x_nxt_s;
    logic [RW-1:0]    y_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic [RW-1:0]    root_r;
    logic             accept_s;
    logic             step_s;
    logic             last_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;

    cbrt_step #(
        .WIDTH (WIDTH),
        .RW    (RW),
        .SW    (SW)
    ) u_step (
        .x      (x_r),
        .y      (y_r),
        .s      (s_r),
        .x_next (x_nxt_s),
        .y_next (y_nxt_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a start during CALC is simply not looked at.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = start ? CALC : IDLE;
            CALC:    state_nxt_s = (s_r == {SW{1'b0}}) ? DONE : CALC;
            DONE:    state_nxt_s = start ? CALC : IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control decode feeding the datapath and the registered handshake.
    always_comb begin
        accept_s = 1'b0;
        step_s   = 1'b0;
        case (state_r)
            IDLE:    accept_s = start;
            CALC:    step_s   = 1'b1;
            DONE:    accept_s = start;
            default: accept_s = 1'b0;
        endcase
        last_s     = step_s && (s_r == {SW{1'b0}});
        busy_nxt_s = (state_nxt_s == CALC);
        done_nxt_s = (state_nxt_s == DONE);
    end

    // Iteration registers and held results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r    <= {WIDTH{1'b0}};
            y_r    <= {RW{1'b0}};
            s_r    <= {SW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            root_r <= {RW{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (accept_s) begin
                x_r <= operand;
                y_r <= {RW{1'b0}};
                s_r <= S_INIT;
            end else if (step_s) begin
                x_r <= x_nxt_s;
                y_r <= y_nxt_s;
                if (!last_s) begin
                    s_r <= s_r - S_STEP;
                end
            end
            if (last_s) begin
                root_r <= y_nxt_s;
            end
        end
    end

`ifdef CBRT_REM_EN
    logic [WIDTH-1:0] rem_r;

    // Remainder is the residual x captured alongside the root.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r <= {WIDTH{1'b0}};
        end else if (last_s) begin
            rem_r <= x_nxt_s;
        end
    end

    assign remainder = rem_r;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign root = root_r;

endmodule
